// File: rtl/bus_copy_initiator.sv
// Word-copy initiator on the req/ack/resp memory bus: reads len words from a
// source address and writes each to a destination, one transaction at a time.
module bus_copy_initiator #(
   parameter int len_width = 16,
   parameter int timeout   = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [31:0]          src_addr_bi,
   input  logic [31:0]          dst_addr_bi,
   input  logic [len_width-1:0] len_bi,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [len_width-1:0] words_bo,
   output logic                 bus_req_o,
   output logic                 bus_we_o,
   output logic [31:0]          bus_addr_bi,
   output logic [3:0]           bus_be_bi,
   output logic [31:0]          bus_wdata_bi,
   input  logic                 bus_ack_i,
   input  logic                 bus_resp_i,
   input  logic [31:0]          bus_rdata_bi
);

   localparam int CNT_W = $clog2(timeout + 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(timeout - 1);
   localparam logic [len_width-1:0] WORD_ONE = len_width'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      FIN     = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [31:0]          src_r, src_s;
   logic [31:0]          dst_r, dst_s;
   logic [len_width-1:0] len_r, len_s;
   logic [len_width-1:0] words_r, words_s;
   logic [len_width-1:0] words_inc_s;
   logic [31:0]          data_r, data_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic                 err_r, err_s;
   logic                 wait_last_s;

   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic                 req_r, req_s;
   logic                 we_r, we_s;
   logic [31:0]          addr_r, addr_s;
   logic [3:0]           be_r, be_s;
   logic [31:0]          wdata_r, wdata_s;

   assign words_inc_s = words_r + WORD_ONE;
   // The stalled state aborts on the cycle that completes `timeout` waits.
   assign wait_last_s = (cnt_r == CNT_LAST);

   // Next-state and datapath update; the wait counter restarts on every state entry.
   always_comb begin
      state_s = state_r;
      src_s   = src_r;
      dst_s   = dst_r;
      len_s   = len_r;
      words_s = words_r;
      data_s  = data_r;
      err_s   = err_r;
      cnt_s   = {CNT_W{1'b0}};
      case (state_r)
         IDLE: begin
            if (start_i) begin
               src_s   = src_addr_bi;
               dst_s   = dst_addr_bi;
               len_s   = len_bi;
               err_s   = 1'b0;
               words_s = {len_width{1'b0}};
               if (len_bi == {len_width{1'b0}}) begin
                  state_s = FIN;
               end else begin
                  state_s = RD_REQ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RD_REQ: begin
            if (bus_ack_i) begin
               src_s   = src_r + 32'd4;
               state_s = RD_WAIT;
            end else if (wait_last_s) begin
               err_s   = 1'b1;
               state_s = FIN;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         RD_WAIT: begin
            if (bus_resp_i) begin
               data_s  = bus_rdata_bi;
               state_s = WR_REQ;
            end else if (wait_last_s) begin
               err_s   = 1'b1;
               state_s = FIN;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         WR_REQ: begin
            if (bus_ack_i) begin
               dst_s   = dst_r + 32'd4;
               words_s = words_inc_s;
               if (words_inc_s < len_r) begin
                  state_s = RD_REQ;
               end else begin
                  state_s = FIN;
               end
            end else if (wait_last_s) begin
               err_s   = 1'b1;
               state_s = FIN;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so they register cleanly.
   always_comb begin
      busy_s  = (state_s != IDLE);
      done_s  = (state_s == FIN);
      req_s   = (state_s == RD_REQ) || (state_s == WR_REQ);
      we_s    = (state_s == WR_REQ);
      be_s    = req_s ? 4'hF : 4'h0;
      if (state_s == RD_REQ) begin
         addr_s = src_s;
      end else if (state_s == WR_REQ) begin
         addr_s = dst_s;
      end else begin
         addr_s = 32'h0000_0000;
      end
      wdata_s = we_s ? data_s : 32'h0000_0000;
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= IDLE;
         src_r   <= 32'h0000_0000;
         dst_r   <= 32'h0000_0000;
         len_r   <= {len_width{1'b0}};
         words_r <= {len_width{1'b0}};
         data_r  <= 32'h0000_0000;
         cnt_r   <= {CNT_W{1'b0}};
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         src_r   <= src_s;
         dst_r   <= dst_s;
         len_r   <= len_s;
         words_r <= words_s;
         data_r  <= data_s;
         cnt_r   <= cnt_s;
         err_r   <= err_s;
      end
   end

   // Registered bus and status outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= 32'h0000_0000;
         be_r    <= 4'h0;
         wdata_r <= 32'h0000_0000;
      end else begin
         busy_r  <= busy_s;
         done_r  <= done_s;
         req_r   <= req_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         be_r    <= be_s;
         wdata_r <= wdata_s;
      end
   end

   assign busy_o       = busy_r;
   assign done_o       = done_r;
   assign err_o        = err_r;
   assign words_bo     = words_r;
   assign bus_req_o    = req_r;
   assign bus_we_o     = we_r;
   assign bus_addr_bi  = addr_r;
   assign bus_be_bi    = be_r;
   assign bus_wdata_bi = wdata_r;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Bench for bus_copy_initiator: behavioural responder plus a cycle/data model
// of each copy run, checked with immediate assertions.
module tb_bus_copy_initiator;

   localparam int LW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [31:0]   src_a, dst_a;
   logic [LW-1:0] len;
   logic          busy, done, err;
   logic [LW-1:0] words;
   logic          req, we;
   logic [31:0]   addr;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          ack, resp;
   logic [31:0]   rdata;

   int vectors     = 0;
   int miscompares = 0;

   int          cyc        = 0;
   int          req_cycles = 0;
   int          req_wait   = 0;
   int          rd_cnt     = 0;
   int          ack_dly    = 0;
   int          resp_dly   = 1;
   bit          no_resp    = 1'b0;
   bit          rd_pend    = 1'b0;
   logic [31:0] rd_data    = 32'h0;
   logic [31:0] src_tbl [256];
   logic [31:0] rd_q [$];
   logic [31:0] wa_q [$];
   logic [31:0] wd_q [$];

   bus_copy_initiator #(.len_width(LW), .timeout(TO)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start),
      .src_addr_bi(src_a), .dst_addr_bi(dst_a), .len_bi(len),
      .busy_o(busy), .done_o(done), .err_o(err), .words_bo(words),
      .bus_req_o(req), .bus_we_o(we), .bus_addr_bi(addr), .bus_be_bi(be),
      .bus_wdata_bi(wdata), .bus_ack_i(ack), .bus_resp_i(resp),
      .bus_rdata_bi(rdata)
   );

   always #5 clk = ~clk;

   // Responder: ack after ack_dly waiting cycles, read data resp_dly cycles after ack.
   assign ack   = req && (req_wait >= ack_dly);
   assign resp  = rd_pend && (rd_cnt == 1) && !no_resp;
   assign rdata = resp ? rd_data : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req) req_cycles <= req_cycles + 1;
      if (req && !ack) req_wait <= req_wait + 1;
      else             req_wait <= 0;
      if (req && ack && !we) begin
         rd_pend <= 1'b1;
         rd_cnt  <= resp_dly;
         rd_data <= src_tbl[addr[9:2]];
         rd_q.push_back(addr);
      end else if (resp) begin
         rd_pend <= 1'b0;
      end else if (rd_pend && rd_cnt > 1) begin
         rd_cnt <= rd_cnt - 1;
      end
      if (req && ack && we) begin
         wa_q.push_back(addr);
         wd_q.push_back(wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] qat(input logic [31:0] q [$], input int i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  32'(busy),  32'h0);
      chk({tag, "_done"},  32'(done),  32'h0);
      chk({tag, "_err"},   32'(err),   32'h0);
      chk({tag, "_words"}, 32'(words), 32'h0);
      chk({tag, "_req"},   32'(req),   32'h0);
      chk({tag, "_we"},    32'(we),    32'h0);
      chk({tag, "_addr"},  addr,       32'h0);
      chk({tag, "_be"},    32'(be),    32'h0);
      chk({tag, "_wdata"}, wdata,      32'h0);
   endtask

   // One copy run against the model: latency, status, bus traffic and copied data.
   task automatic run_copy(input string tag, input logic [31:0] s_a, input logic [31:0] d_a,
                           input int n, input int a_d, input int r_d, input bit nr,
                           input bit fixed_data, input bit ign);
      logic [31:0] srcv [$];
      logic [31:0] sa, sw;
      logic        sv, swe;
      int s, lat, exp_lat, exp_req, exp_rd, exp_wr, rq0, w0, r0;
      ack_dly = a_d; resp_dly = r_d; no_resp = nr;
      for (int i = 0; i < n; i++) begin
         logic [31:0] a, v;
         a = s_a + 32'(4 * i);
         v = fixed_data ? (32'(i + 1) * 32'h1111_1111) : $urandom;
         src_tbl[a[9:2]] = v;
         srcv.push_back(v);
      end
      if (n == 0) begin
         exp_lat = 1; exp_req = 0; exp_rd = 0; exp_wr = 0;
      end else if (nr) begin
         exp_lat = 2 + a_d + TO; exp_req = a_d + 1; exp_rd = 1; exp_wr = 0;
      end else begin
         exp_lat = 1 + n * (2 * (a_d + 1) + r_d); exp_req = 2 * n * (a_d + 1);
         exp_rd = n; exp_wr = n;
      end
      rq0 = req_cycles; w0 = wa_q.size(); r0 = rd_q.size();
      @(negedge clk);
      start = 1'b1; src_a = s_a; dst_a = d_a; len = LW'(n); s = cyc;
      @(negedge clk);
      start = 1'b0; src_a = 32'h0; dst_a = 32'h0; len = '0;
      chk({tag, "_busy_on"}, 32'(busy), 32'h1);
      chk({tag, "_err_clr"}, 32'(err),  32'h0);
      lat = -1; sv = 1'b0; sa = 32'h0; sw = 32'h0; swe = 1'b0;
      for (int k = 0; k < 400 && lat < 0; k++) begin
         if (sv && req) begin
            chk({tag, "_stable_addr"},  addr,     sa);
            chk({tag, "_stable_we"},    32'(we),  32'(swe));
            chk({tag, "_stable_wdata"}, wdata,    sw);
         end
         sv = req && !ack; sa = addr; sw = wdata; swe = we;
         if (done) begin
            lat = cyc - s;
         end else begin
            start = ign && (k == 2);
            if (start) begin
               src_a = 32'h0000_0380; dst_a = 32'h0000_03C0; len = LW'(1);
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"},     32'(err), 32'(nr && n > 0));
      chk({tag, "_words"},   32'(words), nr ? 32'h0 : 32'(n));
      chk({tag, "_req_cycles"}, 32'(req_cycles - rq0), 32'(exp_req));
      chk({tag, "_rd_count"},   32'(rd_q.size() - r0), 32'(exp_rd));
      chk({tag, "_wr_count"},   32'(wa_q.size() - w0), 32'(exp_wr));
      for (int i = 0; i < exp_rd; i++)
         chk({tag, "_rd_addr"}, qat(rd_q, r0 + i), s_a + 32'(4 * i));
      for (int i = 0; i < exp_wr; i++) begin
         chk({tag, "_wr_addr"}, qat(wa_q, w0 + i), d_a + 32'(4 * i));
         chk({tag, "_wr_data"}, qat(wd_q, w0 + i), srcv[i]);
      end
      @(negedge clk);
      chk({tag, "_busy_off"}, 32'(busy), 32'h0);
      chk({tag, "_done_off"}, 32'(done), 32'h0);
      chk({tag, "_req_off"},  32'(req),  32'h0);
   endtask

   initial begin
      int w0;
      rst_n = 1'b0; start = 1'b0; src_a = 32'h0; dst_a = 32'h0; len = '0;
      for (int i = 0; i < 256; i++) src_tbl[i] = 32'h0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("post_reset");

      run_copy("basic",    32'h0000_0000, 32'h0000_0100, 4, 0, 1, 1'b0, 1'b1, 1'b0);
      run_copy("zero_len", 32'h0000_0040, 32'h0000_0140, 0, 0, 1, 1'b0, 1'b0, 1'b0);
      run_copy("backpr",   32'h0000_0020, 32'h0000_0120, 2, 2, 3, 1'b0, 1'b0, 1'b0);
      run_copy("timeout",  32'h0000_0060, 32'h0000_0160, 5, 0, 1, 1'b1, 1'b0, 1'b0);
      run_copy("recover",  32'h0000_0060, 32'h0000_0160, 3, 0, 1, 1'b0, 1'b0, 1'b0);
      run_copy("wrap",     32'hFFFF_FFF8, 32'h0000_0200, 3, 0, 1, 1'b0, 1'b0, 1'b0);
      run_copy("ign_start",32'h0000_0080, 32'h0000_0240, 3, 1, 2, 1'b0, 1'b0, 1'b1);

      // Reset asserted in the write of the second word.
      ack_dly = 0; resp_dly = 1; no_resp = 1'b0;
      for (int i = 0; i < 4; i++) src_tbl[i] = $urandom;
      w0 = wa_q.size();
      @(negedge clk);
      start = 1'b1; src_a = 32'h0; dst_a = 32'h0000_0140; len = LW'(4);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_pre_we",    32'(we),    32'h1);
      chk("rst_mid_pre_words", 32'(words), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("rst_release");
      chk("rst_wr_count", 32'(wa_q.size() - w0), 32'h1);

      for (int r = 0; r < 6; r++) begin
         logic [31:0] sa, da;
         sa = ($urandom & 32'hFFFF_FC00) | 32'h0000_0300 | 32'($urandom_range(7, 0) << 2);
         da = ($urandom & 32'hFFFF_FC00) | 32'h0000_0380 | 32'($urandom_range(7, 0) << 2);
         run_copy("random", sa, da, int'($urandom_range(6, 1)), int'($urandom_range(2, 0)),
                  int'($urandom_range(3, 1)), 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_copy_initiator.md
# bus_copy_initiator

Word-copy engine that acts as an initiator on the team's req/ack/resp memory bus. On a start pulse it reads `len` 32-bit words from a source address and writes each one to a destination address, one transaction at a time. It sits between a control register block and a bus responder such as the dual-port RAM wrappers. A per-transaction timeout keeps a stalled responder from hanging the engine.

## Interface
- `len_width`, 16: width of the word-count input and progress counter.
- `timeout`, 255: number of cycles allowed in any single bus-wait state before abort; must be ≥ 1.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset; one clock, reset is asynchronous and active-low.
- `start_i` in 1: one-cycle start pulse; sampled only in IDLE.
- `src_addr_bi` in 32: source byte address, captured at start.
- `dst_addr_bi` in 32: destination byte address, captured at start.
- `len_bi` in len_width: number of words to copy, captured at start.
- `busy_o` out 1: high from the cycle after an accepted start until the cycle `done_o` pulses (inclusive).
- `done_o` out 1: one-cycle completion pulse, on both normal and aborted finish.
- `err_o` out 1: sticky timeout flag; cleared by the next accepted start.
- `words_bo` out len_width: count of words fully written in the current or last run.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: 1 = write, 0 = read; valid while req.
- `bus_addr_bi` out 32: byte address; valid while req.
- `bus_be_bi` out 4: byte enables; always 4'hF while req, 4'h0 otherwise.
- `bus_wdata_bi` out 32: write data; valid while req and we.
- `bus_ack_i` in 1: responder accepted the request this cycle. May be combinational from req.
- `bus_resp_i` in 1: read data valid this cycle. Writes produce no resp.
- `bus_rdata_bi` in 32: read data, valid when resp is high.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- **IDLE**
  - On `start_i`: capture src, dst and len; clear `err_o` and `words_bo`.
  - If len = 0, go to FIN; otherwise go to RD_REQ.
- **RD_REQ**
  - Drive req = 1, we = 0, addr = current src.
  - On ack: go to RD_WAIT, src += 4.
- **RD_WAIT**
  - req = 0.
  - On resp: latch rdata into the data register and go to WR_REQ.
  - resp in the same cycle as ack is not possible; responders deliver resp at least 1 cycle after ack.
- **WR_REQ**
  - Drive req = 1, we = 1, addr = current dst, wdata = data register.
  - On ack: dst += 4 and words += 1.
  - Then go to RD_REQ if words + 1 < len, else go to FIN.
- **FIN**
  - Pulse `done_o` for one cycle, then return to IDLE.
- Timeout:
  - A wait counter resets on every state entry and increments each cycle spent in RD_REQ, RD_WAIT or WR_REQ without the completing event.
  - When the counter reaches `timeout`, set `err_o` = 1, drop req that same cycle and go to FIN.
  - `words_bo` keeps the partial count.
- Address arithmetic is modulo 2^32; increments wrap silently from 32'hFFFFFFFC to 0. Address bits [1:0] are passed through unchanged.
- Length is unsigned; the maximum is 2^len_width − 1 words.
- `bus_resp_i` outside RD_WAIT is ignored. `start_i` outside IDLE is ignored.
- Reset:
  - Asserting `rst_i` low forces IDLE and all outputs to 0 immediately.
  - This includes mid-transaction; a request in flight is abandoned.
  - Reset values of every output: 0, including `bus_addr_bi`, `bus_wdata_bi` and `words_bo`.

## Timing
- At most one transaction outstanding; req is never asserted in RD_WAIT.
- Req, we, addr and wdata are held stable from req assertion until the ack cycle inclusive.
- Per-word cost against a zero-wait responder (ack = req, resp registered one cycle later) is 3 cycles:
  - cycle k: RD_REQ, ack;
  - cycle k+1: RD_WAIT, resp;
  - cycle k+2: WR_REQ, ack;
  - cycle k+3: next RD_REQ or FIN.
- Start at cycle s:
  - first req at s+1;
  - for len = N, `done_o` at s+1+3N;
  - for len = 0, `done_o` at s+1.
- `busy_o` goes low the cycle after `done_o`. A new start is accepted in that same cycle.
- Timeout: with no ack and no resp, err and done assert in the cycle after `timeout` cycles of waiting in the stalled state.

## Test plan
- **Basic copy.** Zero-wait RAM preloaded with words 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; src = 0x0, dst = 0x100, len = 4.
  - Required: 0x100..0x10C hold the same values.
  - `done_o` exactly 13 cycles after start; `words_bo` = 4; `err_o` = 0.
- **Zero length.** len = 0.
  - Required: no req ever asserted; `done_o` pulses the cycle after start; `busy_o` high for 1 cycle.
- **Backpressure.** Responder delays ack by 2 cycles and resp by 3 cycles, len = 2.
  - Required: req, addr and wdata stable until ack; data copied correctly; no timeout.
- **Timeout.** timeout = 8; responder never asserts resp, len = 5.
  - Required: `err_o` = 1; `done_o` pulses; `words_bo` = 0; req is low after the abort.
  - The next start with a healthy responder clears err and completes normally.
- **Wrap-around.** src = 0xFFFFFFF8, len = 3.
  - Required: read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- **Reset and ignored starts.** Pull `rst_i` low during WR_REQ of word 2.
  - Required: all outputs 0 immediately; IDLE after release.
  - A start pulsed while busy has no effect on the running copy.
